// File: rtl/serial_shift_arbiter.sv
// serial_shift_arbiter
//   Shares one MSB-first serial display channel (sck/sdat/lat) between two
//   frame requesters. Grants round-robin from IDLE, captures the winner's
//   parallel word, shifts it out with a registered divided clock, then spends
//   one LATCH cycle pulsing lat and the winner's ack bit.
//
// Ports
//   i_clk       system clock, all state on rising edge
//   i_clrn      asynchronous active-low reset
//   i_req[1:0]  per-requester frame request (level, held until ack)
//   i_data0/1   frame words, sampled only at grant
//   o_ack[1:0]  one-cycle pulse to the requester whose frame was latched
//   o_busy      high during SHIFT and LATCH
//   o_grant_id  requester of the frame in progress (holds when idle)
//   o_sck       shift clock, receiver samples o_sdat on its rising edge
//   o_sdat      serial data, MSB first
//   o_lat       one-cycle latch strobe after the last bit
module serial_shift_arbiter #(
   parameter int WIDTH = 16,
   parameter int DIV   = 2
) (
   input  logic             i_clk,
   input  logic             i_clrn,
   input  logic [1:0]       i_req,
   input  logic [WIDTH-1:0] i_data0,
   input  logic [WIDTH-1:0] i_data1,
   output logic [1:0]       o_ack,
   output logic             o_busy,
   output logic             o_grant_id,
   output logic             o_sck,
   output logic             o_sdat,
   output logic             o_lat
);

   localparam int BW = $clog2(WIDTH);
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_shreg;
   logic [BW-1:0]    r_bit;
   logic [DW-1:0]    r_div;
   logic             r_prio;     // requester favoured when both request
   logic [1:0]       r_ack;
   logic             r_busy;
   logic             r_gid;
   logic             r_sck;
   logic             r_sdat;
   logic             r_lat;

   logic             w_win;
   logic [WIDTH-1:0] w_word;

   // With a single request, req[1] is exactly the index of the one that is high.
   assign w_win  = (i_req == 2'b11) ? r_prio : i_req[1];
   assign w_word = w_win ? i_data1 : i_data0;

   always_ff @(posedge i_clk or negedge i_clrn) begin
      if (!i_clrn) begin
         r_state <= S_IDLE;
         r_shreg <= '0;
         r_bit   <= '0;
         r_div   <= '0;
         r_prio  <= 1'b0;
         r_ack   <= 2'b00;
         r_busy  <= 1'b0;
         r_gid   <= 1'b0;
         r_sck   <= 1'b0;
         r_sdat  <= 1'b0;
         r_lat   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_sck  <= 1'b0;
               r_sdat <= 1'b0;
               r_lat  <= 1'b0;
               r_ack  <= 2'b00;
               r_busy <= 1'b0;
               if (|i_req) begin
                  r_shreg <= w_word;
                  r_sdat  <= w_word[WIDTH-1];
                  r_gid   <= w_win;
                  r_busy  <= 1'b1;
                  r_bit   <= '0;
                  r_div   <= '0;
                  r_state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (r_div == DW'(DIV - 1)) begin
                  r_div <= '0;
                  if (!r_sck) begin
                     r_sck <= 1'b1;
                  end else begin
                     // End of a bit's high phase: next bit or finish.
                     r_sck <= 1'b0;
                     if (r_bit == BW'(WIDTH - 1)) begin
                        r_sdat  <= 1'b0;
                        r_lat   <= 1'b1;
                        r_ack   <= r_gid ? 2'b10 : 2'b01;
                        r_state <= S_LATCH;
                     end else begin
                        r_bit   <= r_bit + BW'(1);
                        r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
                        r_sdat  <= r_shreg[WIDTH-2];
                     end
                  end
               end else begin
                  r_div <= r_div + DW'(1);
               end
            end
            S_LATCH: begin
               r_lat   <= 1'b0;
               r_ack   <= 2'b00;
               r_busy  <= 1'b0;
               // Just-served requester loses the next tie.
               r_prio  <= ~r_gid;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_ack      = r_ack;
   assign o_busy     = r_busy;
   assign o_grant_id = r_gid;
   assign o_sck      = r_sck;
   assign o_sdat     = r_sdat;
   assign o_lat      = r_lat;

endmodule
